writeback_regfile: RTL and testbench
====================================

# writeback_regfile

Writeback-stage consumer of the MEM/WB pipeline register, sitting at the other end of the memory-to-writeback interface. It selects the writeback result from the memory read data or the ALU result and commits that value to a 32-entry general-purpose register file. It serves the decode stage's two combinational read ports with same-cycle write-through bypass, and keeps a committed-write counter for debug and verification.

## Interface
Parameters:
- DATA_WIDTH, 32, register and result width
- ADDR_WIDTH, 5, register index width; the file depth is 2**ADDR_WIDTH

Ports:
- Clk  input  1  the single clock; all state updates on its rising edge
- Rst  input  1  asynchronous, active-high reset
- MemtoRegW  input  1  writeback source select; 1 = MemReadDataW, 0 = ALUResultW
- RegWriteW  input  1  write enable for the writeback stage
- WriteRegW  input  ADDR_WIDTH  destination register index
- MemReadDataW  input  DATA_WIDTH  load data from the MEM/WB register
- ALUResultW  input  DATA_WIDTH  ALU result from the MEM/WB register
- ReadReg1D, ReadReg2D  input  ADDR_WIDTH  decode-stage source indices
- ReadData1D, ReadData2D  output  DATA_WIDTH  decode-stage source values (combinational)
- ResultW  output  DATA_WIDTH  selected writeback value (combinational)
- DbgAddr  input  ADDR_WIDTH  debug read index
- DbgData  output  DATA_WIDTH  raw array contents at DbgAddr, with no bypass
- WriteCount  output  32  count of committed register writes

## Operation
- ResultW = MemtoRegW ? MemReadDataW : ALUResultW, at full DATA_WIDTH with no extension or truncation.
- Commit condition: RegWriteW = 1 and WriteRegW ≠ 0 and Rst = 0.
  - On a commit, the rising edge of Clk stores ResultW into entry WriteRegW.
  - On the same edge, WriteCount increments by 1. It wraps from 0xFFFFFFFF to 0.
- Register 0 is hardwired to zero.
  - Writes to index 0 are discarded and do not increment WriteCount.
  - Reads of index 0 always return 0, both through the bypass and through DbgData.
- Read ports. For each port n:
  - If ReadRegnD = WriteRegW, RegWriteW = 1 and ReadRegnD ≠ 0, then ReadDatanD = ResultW (write-through bypass).
  - Otherwise ReadDatanD = array[ReadRegnD].
- Both read ports may address the same register, and either may hit the bypass. The two ports evaluate independently.
- DbgData reflects committed state only and never bypasses.
- Reset:
  - Asserting Rst immediately clears all entries and WriteCount to 0.
  - While Rst is high, ReadData1D, ReadData2D and DbgData read 0, the bypass is suppressed, and no commit occurs.
  - ResultW stays purely combinational, including during reset.

## Timing
- Reset value of every output: ReadData1D = ReadData2D = DbgData = 0 and WriteCount = 0. ResultW follows its inputs.
- Write latency: one edge. A value presented in cycle N is in the array after edge N and visible on DbgData in cycle N+1.
- Read-after-write in the same cycle returns the new value through the bypass with zero latency. This replaces a negedge-write scheme, so only the single rising-edge domain exists.
- There is no handshake; the MEM/WB register supplies one instruction per cycle and this block accepts it unconditionally.
- Reset released between edges: the first commit can occur on the next rising edge.
- Reset asserted mid-cycle while a commit is pending: the commit is lost and the array is zero.

## Structure
- The shared package holds REG_ZERO = 0, the default DATA_WIDTH and ADDR_WIDTH, and the MemtoReg encoding constants (SEL_ALU = 0, SEL_MEM = 1).
- One sub-module, regfile_array, holds the storage array, the async clear, the guarded write port and three raw read ports.
- The top level holds the result mux, the bypass comparators and the WriteCount counter.

## Test plan
- Reset: assert Rst with random inputs, then read all 32 indices via DbgData → every read is 0, WriteCount = 0, ReadData1D/2D = 0.
- Basic write: RegWriteW = 1, MemtoRegW = 0, WriteRegW = 5, ALUResultW = 0xDEADBEEF, one edge → DbgAddr = 5 reads 0xDEADBEEF, WriteCount = 1.
- Mux and bypass: MemtoRegW = 1, MemReadDataW = 0x12345678, WriteRegW = 9, ReadReg1D = ReadReg2D = 9, sampled before the edge → both read ports return 0x12345678 while DbgAddr = 9 still reads the old value (0).
- Register zero: WriteRegW = 0, RegWriteW = 1, ALUResultW = 0xFFFFFFFF, ReadReg1D = 0 → ReadData1D = 0 before and after the edge, WriteCount unchanged.
- RegWriteW = 0: WriteRegW = 5, ReadReg1D = 5, ALUResultW = 0x1 → no bypass, ReadData1D = 0xDEADBEEF, entry 5 unchanged.
- Reset mid-run: after 10 commits, assert Rst asynchronously between edges → outputs drop to 0 before the next edge, and WriteCount = 0. Separately, force WriteCount to 0xFFFFFFFF and commit once → WriteCount = 0.

Source files
------------

// File: rtl/writeback_regfile_pkg.sv
// Shared constants for the writeback stage: default widths, register-zero
// index and the MemtoReg source-select encoding.
package writeback_regfile_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int REG_ZERO       = 0;

    localparam logic SEL_ALU = 1'b0;
    localparam logic SEL_MEM = 1'b1;

    localparam int NUM_RD = 3;  // two decode ports plus the debug port
endpackage

// File: rtl/writeback_regfile_if.sv
// MEM/WB-to-writeback bus plus the decode read ports and debug taps.
// master = pipeline/decode side, slave = the register file block.
interface writeback_regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  MemtoRegW;
    logic                  RegWriteW;
    logic [ADDR_WIDTH-1:0] WriteRegW;
    logic [DATA_WIDTH-1:0] MemReadDataW;
    logic [DATA_WIDTH-1:0] ALUResultW;
    logic [ADDR_WIDTH-1:0] ReadReg1D;
    logic [ADDR_WIDTH-1:0] ReadReg2D;
    logic [DATA_WIDTH-1:0] ReadData1D;
    logic [DATA_WIDTH-1:0] ReadData2D;
    logic [DATA_WIDTH-1:0] ResultW;
    logic [ADDR_WIDTH-1:0] DbgAddr;
    logic [DATA_WIDTH-1:0] DbgData;
    logic [31:0]           WriteCount;

    modport master (
        output MemtoRegW, RegWriteW, WriteRegW, MemReadDataW, ALUResultW,
        output ReadReg1D, ReadReg2D, DbgAddr,
        input  ReadData1D, ReadData2D, ResultW, DbgData, WriteCount
    );

    modport slave (
        input  MemtoRegW, RegWriteW, WriteRegW, MemReadDataW, ALUResultW,
        input  ReadReg1D, ReadReg2D, DbgAddr,
        output ReadData1D, ReadData2D, ResultW, DbgData, WriteCount
    );
endinterface

// File: rtl/writeback_regfile_regfile_array.sv
// Register storage: async clear, guarded single write port, raw read ports.
// Reads return zero for index 0 and while reset is held.
module regfile_array
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RD_PORTS   = NUM_RD
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 we,
    input  logic [ADDR_WIDTH-1:0]                waddr,
    input  logic [DATA_WIDTH-1:0]                wdata,
    input  logic [RD_PORTS-1:0][ADDR_WIDTH-1:0]  raddr,
    output logic [RD_PORTS-1:0][DATA_WIDTH-1:0]  rdata
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (we && waddr != ADDR_WIDTH'(REG_ZERO)) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        assign rdata[p] = (rst || raddr[p] == ADDR_WIDTH'(REG_ZERO)) ? '0 : mem[raddr[p]];
    end
endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: result mux, commit into the register file, decode read
// ports with same-cycle write-through bypass, and a committed-write counter.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst,
    writeback_regfile_if.slave   wb
);
    logic                                 commit;
    logic [DATA_WIDTH-1:0]                result;
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    raddr;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rdata;
    logic [1:0][DATA_WIDTH-1:0]           rd_out;
    logic [31:0]                          write_count;

    assign result    = (wb.MemtoRegW == SEL_MEM) ? wb.MemReadDataW : wb.ALUResultW;
    assign wb.ResultW = result;

    assign commit = wb.RegWriteW && (wb.WriteRegW != ADDR_WIDTH'(REG_ZERO)) && !Rst;

    assign raddr[0] = wb.ReadReg1D;
    assign raddr[1] = wb.ReadReg2D;
    assign raddr[2] = wb.DbgAddr;

    regfile_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RD_PORTS   (NUM_RD)
    ) u_array (
        .clk   (Clk),
        .rst   (Rst),
        .we    (commit),
        .waddr (wb.WriteRegW),
        .wdata (result),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Decode ports see the value being written this cycle; debug port does not.
    for (genvar p = 0; p < 2; p++) begin : g_byp
        logic hit;
        assign hit       = commit && (raddr[p] == wb.WriteRegW);
        assign rd_out[p] = hit ? result : rdata[p];
    end

    assign wb.ReadData1D = rd_out[0];
    assign wb.ReadData2D = rd_out[1];
    assign wb.DbgData    = rdata[2];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            write_count <= '0;
        end else if (commit) begin
            write_count <= write_count + 32'd1;
        end
    end

    assign wb.WriteCount = write_count;
endmodule

// File: tb/tb_writeback_regfile.sv
// Directed self-checking bench for writeback_regfile.
module tb_writeback_regfile;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    writeback_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) wb ();

    writeback_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .wb  (wb)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic sel, input logic [4:0] wr,
                         input logic [31:0] mem, input logic [31:0] alu);
        wb.RegWriteW    = we;
        wb.MemtoRegW    = sel;
        wb.WriteRegW    = wr;
        wb.MemReadDataW = mem;
        wb.ALUResultW   = alu;
    endtask

    initial begin
        // Reset with random inputs, including an apparent bypass hit on port 1
        drive(1'b1, 1'b0, 5'd7, $urandom, 32'hA5A5_0001);
        wb.ReadReg1D = 5'd7;
        wb.ReadReg2D = 5'($urandom_range(1, 31));
        wb.DbgAddr   = '0;
        #1;
        check("rst_resultw", wb.ResultW, 32'hA5A5_0001);
        tick();
        tick();
        check("rst_rd1", wb.ReadData1D, 32'h0);
        check("rst_rd2", wb.ReadData2D, 32'h0);
        check("rst_count", wb.WriteCount, 32'h0);
        for (int i = 0; i < 32; i++) begin
            wb.DbgAddr = 5'(i);
            #1;
            check($sformatf("rst_dbg%0d", i), wb.DbgData, 32'h0);
        end

        // Release between edges; first commit on the next edge
        @(negedge Clk);
        Rst = 1'b0;
        drive(1'b1, 1'b0, 5'd5, 32'h0BAD_0BAD, 32'hDEAD_BEEF);
        wb.ReadReg1D = 5'd1;
        wb.ReadReg2D = 5'd2;
        wb.DbgAddr   = 5'd5;
        tick();
        check("basic_dbg5", wb.DbgData, 32'hDEAD_BEEF);
        check("basic_count", wb.WriteCount, 32'd1);

        // Mem source + bypass on both ports; debug shows old value
        @(negedge Clk);
        drive(1'b1, 1'b1, 5'd9, 32'h1234_5678, 32'h5555_AAAA);
        wb.ReadReg1D = 5'd9;
        wb.ReadReg2D = 5'd9;
        wb.DbgAddr   = 5'd9;
        #1;
        check("mux_resultw", wb.ResultW, 32'h1234_5678);
        check("byp_rd1", wb.ReadData1D, 32'h1234_5678);
        check("byp_rd2", wb.ReadData2D, 32'h1234_5678);
        check("byp_dbg9_old", wb.DbgData, 32'h0);
        tick();
        check("byp_dbg9_new", wb.DbgData, 32'h1234_5678);
        check("byp_count", wb.WriteCount, 32'd2);

        // Register zero discards the write
        @(negedge Clk);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF);
        wb.ReadReg1D = 5'd0;
        wb.DbgAddr   = 5'd0;
        #1;
        check("r0_rd1_pre", wb.ReadData1D, 32'h0);
        tick();
        check("r0_rd1_post", wb.ReadData1D, 32'h0);
        check("r0_dbg", wb.DbgData, 32'h0);
        check("r0_count", wb.WriteCount, 32'd2);

        // RegWriteW low: no bypass, no write
        @(negedge Clk);
        drive(1'b0, 1'b0, 5'd5, 32'h0, 32'h0000_0001);
        wb.ReadReg1D = 5'd5;
        wb.DbgAddr   = 5'd5;
        #1;
        check("nowe_rd1", wb.ReadData1D, 32'hDEAD_BEEF);
        tick();
        check("nowe_dbg5", wb.DbgData, 32'hDEAD_BEEF);
        check("nowe_count", wb.WriteCount, 32'd2);

        // Independent ports: only port 2 matches the write
        @(negedge Clk);
        drive(1'b1, 1'b0, 5'd9, 32'h0, 32'hCAFE_F00D);
        wb.ReadReg1D = 5'd5;
        wb.ReadReg2D = 5'd9;
        #1;
        check("ind_rd1", wb.ReadData1D, 32'hDEAD_BEEF);
        check("ind_rd2", wb.ReadData2D, 32'hCAFE_F00D);
        tick();
        check("ind_count", wb.WriteCount, 32'd3);

        // Ten commits to r1..r10
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clk);
            drive(1'b1, 1'b0, 5'(i), 32'h0, 32'h1111_1111 * i);
        end
        tick();
        @(negedge Clk);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        wb.DbgAddr = 5'd3;
        #1;
        check("multi_dbg3", wb.DbgData, 32'h3333_3333);
        wb.DbgAddr = 5'd10;
        #1;
        check("multi_dbg10", wb.DbgData, 32'hAAAA_AAAA);
        check("multi_count", wb.WriteCount, 32'd13);

        // Async reset mid-cycle with a commit pending
        @(posedge Clk);
        #2;
        drive(1'b1, 1'b0, 5'd11, 32'h0, 32'h7777_7777);
        wb.ReadReg1D = 5'd3;
        wb.ReadReg2D = 5'd11;
        wb.DbgAddr   = 5'd3;
        #1;
        Rst = 1'b1;
        #1;
        check("arst_rd1", wb.ReadData1D, 32'h0);
        check("arst_rd2_nobyp", wb.ReadData2D, 32'h0);
        check("arst_dbg3", wb.DbgData, 32'h0);
        check("arst_count", wb.WriteCount, 32'h0);
        tick();
        Rst = 1'b0;
        wb.DbgAddr = 5'd11;
        #1;
        check("arst_lost", wb.DbgData, 32'h0);
        tick();
        check("post_rst_dbg11", wb.DbgData, 32'h7777_7777);
        check("post_rst_count", wb.WriteCount, 32'd1);

        // Counter wrap
        @(negedge Clk);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        force dut.write_count = 32'hFFFF_FFFF;
        #1;
        release dut.write_count;
        #1;
        check("wrap_pre", wb.WriteCount, 32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 5'd4, 32'h0, 32'h0000_0044);
        tick();
        check("wrap_count", wb.WriteCount, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
